// File: rtl/arrow_input_encoder.sv
// Button front end: synchronizes and debounces the four direction buttons, groups
// near-simultaneous presses into a chord and emits one arrow code (10..20) per chord.
module arrow_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_BITS         = 19,
  parameter int CHORD_CYCLES    = 2000000,
  parameter int CHORD_BITS      = 21
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Up,
  input  logic       Down,
  input  logic       Left,
  input  logic       Right,
  input  logic       enable,
  output logic [4:0] arrow_code,
  output logic       arrow_valid,
  output logic       invalid_chord,
  output logic [3:0] held
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] COLLECT      = 2'd1;
  localparam logic [1:0] EMIT         = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  localparam logic [DB_BITS-1:0]    DB_LAST    = DB_BITS'(DEBOUNCE_CYCLES - 1);
  localparam logic [CHORD_BITS-1:0] CHORD_LAST = CHORD_BITS'(CHORD_CYCLES - 1);

  function automatic logic [2:0] popCount(input logic [3:0] m);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'd0, m[i]};
    end
    return n;
  endfunction

  // Mask bit order is {Up,Down,Left,Right}; any chord of three or more maps to 20.
  function automatic logic [4:0] encodeMask(input logic [3:0] m);
    logic [4:0] c;
    case (m)
      4'b1000: c = 5'd10;
      4'b0100: c = 5'd11;
      4'b0010: c = 5'd12;
      4'b0001: c = 5'd13;
      4'b1100: c = 5'd14;
      4'b1010: c = 5'd15;
      4'b1001: c = 5'd16;
      4'b0110: c = 5'd17;
      4'b0101: c = 5'd18;
      4'b0011: c = 5'd19;
      default: c = 5'd20;
    endcase
    return c;
  endfunction

  logic [3:0]            rawBtn_s;
  logic [3:0]            sync1_r;
  logic [3:0]            sync2_r;
  logic [3:0]            level_r;
  logic [3:0]            levelNext_s;
  logic [3:0]            edge_r;
  logic [DB_BITS-1:0]    dbCnt_r     [4];
  logic [DB_BITS-1:0]    dbCntNext_s [4];
  logic [1:0]            state_r;
  logic [1:0]            stateNext_s;
  logic [3:0]            mask_r;
  logic [3:0]            maskNext_s;
  logic [3:0]            chordMask_s;
  logic [CHORD_BITS-1:0] chordCnt_r;
  logic [CHORD_BITS-1:0] chordCntNext_s;
  logic                  emit_s;

  assign rawBtn_s = {Up, Down, Left, Right};
  assign held     = level_r;

  // Per-button debounce: count while the synced value disagrees with the level.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      levelNext_s[i] = level_r[i];
      dbCntNext_s[i] = {DB_BITS{1'b0}};
      if (sync2_r[i] == level_r[i]) begin
        dbCntNext_s[i] = {DB_BITS{1'b0}};
      end else if (dbCnt_r[i] == DB_LAST) begin
        levelNext_s[i] = ~level_r[i];
        dbCntNext_s[i] = {DB_BITS{1'b0}};
      end else begin
        dbCntNext_s[i] = dbCnt_r[i] + DB_BITS'(1);
      end
    end
  end

  // Synchronizer, debounce state and registered press edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
      level_r <= 4'd0;
      edge_r  <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        dbCnt_r[i] <= {DB_BITS{1'b0}};
      end
    end else begin
      sync1_r <= rawBtn_s;
      sync2_r <= sync1_r;
      level_r <= levelNext_s;
      edge_r  <= levelNext_s & ~level_r;
      for (int i = 0; i < 4; i++) begin
        dbCnt_r[i] <= dbCntNext_s[i];
      end
    end
  end

  // Chord FSM; edges landing on the window-expiry cycle still join the chord.
  always_comb begin
    stateNext_s    = state_r;
    maskNext_s     = mask_r;
    chordCntNext_s = chordCnt_r;
    emit_s         = 1'b0;
    chordMask_s    = mask_r | edge_r;
    if (!enable) begin
      stateNext_s    = IDLE;
      maskNext_s     = 4'd0;
      chordCntNext_s = {CHORD_BITS{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          chordCntNext_s = {CHORD_BITS{1'b0}};
          maskNext_s     = edge_r;
          if (edge_r != 4'd0) begin
            stateNext_s = COLLECT;
          end else begin
            stateNext_s = IDLE;
          end
        end
        COLLECT: begin
          maskNext_s     = chordMask_s;
          chordCntNext_s = chordCnt_r + CHORD_BITS'(1);
          if ((popCount(chordMask_s) >= 3'd2) || (chordCnt_r == CHORD_LAST)) begin
            stateNext_s = EMIT;
            emit_s      = 1'b1;
          end else begin
            stateNext_s = COLLECT;
          end
        end
        EMIT: begin
          stateNext_s = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (level_r == 4'd0) begin
            stateNext_s = IDLE;
            maskNext_s  = 4'd0;
          end else begin
            stateNext_s = WAIT_RELEASE;
          end
        end
        default: begin
          stateNext_s = IDLE;
          maskNext_s  = 4'd0;
        end
      endcase
    end
  end

  // FSM state and registered outputs; the strobe is high exactly while in EMIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      mask_r        <= 4'd0;
      chordCnt_r    <= {CHORD_BITS{1'b0}};
      arrow_code    <= 5'd20;
      arrow_valid   <= 1'b0;
      invalid_chord <= 1'b0;
    end else begin
      state_r       <= stateNext_s;
      mask_r        <= maskNext_s;
      chordCnt_r    <= chordCntNext_s;
      arrow_valid   <= emit_s;
      invalid_chord <= emit_s && (popCount(chordMask_s) >= 3'd3);
      if (emit_s) begin
        arrow_code <= encodeMask(chordMask_s);
      end else begin
        arrow_code <= arrow_code;
      end
    end
  end

endmodule

// File: tb/tb_arrow_input_encoder.sv
// Directed bench for arrow_input_encoder with short debounce/chord windows:
// a chord table plus hand sequences for overlap, glitch, enable abort and reset.
module tb_arrow_input_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0;
  logic       enable = 1'b1;
  logic [4:0] arrow_code;
  logic       arrow_valid;
  logic       invalid_chord;
  logic [3:0] held;

  arrow_input_encoder #(
    .DEBOUNCE_CYCLES(4),
    .DB_BITS(3),
    .CHORD_CYCLES(8),
    .CHORD_BITS(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Up(Up),
    .Down(Down),
    .Left(Left),
    .Right(Right),
    .enable(enable),
    .arrow_code(arrow_code),
    .arrow_valid(arrow_valid),
    .invalid_chord(invalid_chord),
    .held(held)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Output monitor sampled on the falling edge.
  int         cyc = 0;
  int         strobeCnt = 0;
  int         strobeCyc = 0;
  int         lastRiseCyc = 0;
  int         protoErr = 0;
  logic [4:0] strobeCode = 5'd0;
  logic       strobeInv = 1'b0;
  logic       prevValid = 1'b0;
  logic [3:0] prevHeld = 4'd0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (arrow_valid) begin
      strobeCnt  = strobeCnt + 1;
      strobeCyc  = cyc;
      strobeCode = arrow_code;
      strobeInv  = invalid_chord;
    end
    if (arrow_valid && prevValid) protoErr = protoErr + 1;
    if (invalid_chord && !arrow_valid) protoErr = protoErr + 1;
    if ((held & ~prevHeld) != 4'd0) lastRiseCyc = cyc;
    prevValid = arrow_valid;
    prevHeld  = held;
  end

  typedef struct {
    logic [3:0] btn;
    logic [4:0] code;
    logic       inv;
    int         lat;
  } vec_t;

  vec_t vecs [12];

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic setBtn(input logic [3:0] b);
    {Up, Down, Left, Right} = b;
  endtask

  task automatic waitHeld(input logic [3:0] v, input int budget, input string name);
    int n;
    n = 0;
    while (held !== v && n < budget) begin
      step(1);
      n++;
    end
    total = total + 1;
    if (held !== v) begin
      bad = bad + 1;
      $display("FAIL %s held=%b expected=%b after %0d cycles", name, held, v, budget);
    end
  endtask

  task automatic runChord(input logic [3:0] b, input logic [4:0] code, input logic inv,
                          input int lat, input string name);
    int base;
    base = strobeCnt;
    setBtn(b);
    waitHeld(b, 20, {name, "_held"});
    step(15);
    check({name, "_strobes"}, strobeCnt - base, 1);
    check({name, "_code"}, strobeCode, code);
    check({name, "_inv"}, strobeInv, inv);
    check({name, "_lat"}, strobeCyc - lastRiseCyc, lat);
    check({name, "_codeHold"}, arrow_code, code);
    setBtn(4'd0);
    waitHeld(4'd0, 20, {name, "_release"});
    step(5);
    check({name, "_noExtra"}, strobeCnt - base, 1);
  endtask

  initial begin
    int base;
    vecs[0]  = '{4'b1000, 5'd10, 1'b0, 9};
    vecs[1]  = '{4'b0100, 5'd11, 1'b0, 9};
    vecs[2]  = '{4'b0010, 5'd12, 1'b0, 9};
    vecs[3]  = '{4'b0001, 5'd13, 1'b0, 9};
    vecs[4]  = '{4'b1100, 5'd14, 1'b0, 2};
    vecs[5]  = '{4'b1010, 5'd15, 1'b0, 2};
    vecs[6]  = '{4'b1001, 5'd16, 1'b0, 2};
    vecs[7]  = '{4'b0110, 5'd17, 1'b0, 2};
    vecs[8]  = '{4'b0101, 5'd18, 1'b0, 2};
    vecs[9]  = '{4'b0011, 5'd19, 1'b0, 2};
    vecs[10] = '{4'b1101, 5'd20, 1'b1, 2};
    vecs[11] = '{4'b1111, 5'd20, 1'b1, 2};

    step(2);
    check("rst_code", arrow_code, 20);
    check("rst_valid", arrow_valid, 0);
    check("rst_inv", invalid_chord, 0);
    check("rst_held", held, 0);
    reset = 1'b0;
    step(2);

    // Short Down pulse must be filtered.
    base = strobeCnt;
    Down = 1'b1;
    step(2);
    Down = 1'b0;
    step(20);
    check("glitch_held", held, 0);
    check("glitch_strobes", strobeCnt - base, 0);
    check("glitch_code", arrow_code, 20);

    // Up alone: 2 sync + 4 debounce cycles, then a full 8-cycle window.
    base = strobeCnt;
    Up = 1'b1;
    step(5);
    check("up_heldEarly", held, 0);
    step(1);
    check("up_held", held, 4'b1000);
    step(25);
    check("up_strobes", strobeCnt - base, 1);
    check("up_code", strobeCode, 10);
    check("up_inv", strobeInv, 0);
    check("up_lat", strobeCyc - lastRiseCyc, 9);
    Up = 1'b0;
    waitHeld(4'd0, 20, "up_release");
    step(5);

    // Left then Right three cycles later: emits right after Right's edge.
    base = strobeCnt;
    Left = 1'b1;
    step(3);
    Right = 1'b1;
    waitHeld(4'b0011, 20, "lr_held");
    step(30);
    check("lr_strobes", strobeCnt - base, 1);
    check("lr_code", strobeCode, 19);
    check("lr_lat", strobeCyc - lastRiseCyc, 1);
    setBtn(4'd0);
    waitHeld(4'd0, 20, "lr_release");
    step(5);
    check("lr_noExtra", strobeCnt - base, 1);

    for (int i = 0; i < 12; i++) begin
      runChord(vecs[i].btn, vecs[i].code, vecs[i].inv, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Enable dropped mid-window aborts the chord silently.
    base = strobeCnt;
    setBtn(4'b0001);
    waitHeld(4'b0001, 20, "en_held");
    step(4);
    enable = 1'b0;
    step(2);
    enable = 1'b1;
    step(25);
    check("en_abortStrobes", strobeCnt - base, 0);
    check("en_heldTracks", held, 4'b0001);
    setBtn(4'd0);
    waitHeld(4'd0, 20, "en_release");
    step(5);
    check("en_noStrobe", strobeCnt - base, 0);
    runChord(4'b0001, 5'd13, 1'b0, 9, "en_repress");

    // Reset in the middle of a collect window.
    base = strobeCnt;
    setBtn(4'b1000);
    waitHeld(4'b1000, 20, "rst2_held");
    step(3);
    reset = 1'b1;
    #1;
    check("rst2_code", arrow_code, 20);
    check("rst2_held", held, 0);
    check("rst2_valid", arrow_valid, 0);
    setBtn(4'd0);
    step(3);
    reset = 1'b0;
    step(30);
    check("rst2_noStrobe", strobeCnt - base, 0);
    check("rst2_codeKept", arrow_code, 20);
    runChord(4'b1000, 5'd10, 1'b0, 9, "rst2_fresh");

    check("protocol", protoErr, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
